nav_speed_ctrl: RTL and testbench



---
 rtl/nav_pkg.sv | 22 ++
 rtl/opn_edge_det.sv | 37 +++
 rtl/nav_speed_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_nav_speed_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nav_pkg.sv
// nav_pkg: shared types and default constants for the navigation speed sequencer.
//   nav_state_t  - sequencer states
//   decel_rate_t - deceleration rate selector (normal 2x step, emergency 4x step)
//   *_DEF        - default speed constants used as top-level parameter defaults
//   decel_step() - decrement applied per speed tick for a given rate
package nav_pkg;

   typedef enum logic [1:0] {IDLE, TURN, ACCEL, DECEL} nav_state_t;

   typedef enum logic {RATE_NORM, RATE_EMERG} decel_rate_t;

   localparam logic [10:0] MAX_FRWRD_DEF  = 11'h2A0;
   localparam logic [10:0] MIN_FRWRD_DEF  = 11'h0D0;
   localparam logic [10:0] FRWRD_INC_DEF  = 11'h018;
   localparam int unsigned SETTLE_CYC_DEF = 2;

   // The acceleration step must stay small enough that 4x fits in 11 bits.
   function automatic logic [10:0] decel_step(decel_rate_t rate, logic [10:0] inc);
      return (rate == RATE_EMERG) ? (inc << 2) : (inc << 1);
   endfunction

endpackage

// File: rtl/opn_edge_det.sv
// opn_edge_det: rising-edge detector for the left/right IR opening flags.
//   clk, rst_n          - clock, async active-low reset
//   load                - move start: capture current openings as the baseline
//   en                  - track openings and report edges (high while accelerating)
//   lft_opn, rght_opn   - IR opening levels
//   lft_rise, rght_rise - one-cycle rising-edge pulses, only while en is high
module opn_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   input  logic lft_opn,
   input  logic rght_opn,
   output logic lft_rise,
   output logic rght_rise
);

   logic lft_prev_q;
   logic rght_prev_q;

   // Loading at move start means an opening already present then is never seen as an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lft_prev_q  <= 1'b0;
         rght_prev_q <= 1'b0;
      end else if (load || en) begin
         lft_prev_q  <= lft_opn;
         rght_prev_q <= rght_opn;
      end
   end

   always_comb begin
      lft_rise  = en && lft_opn && !lft_prev_q;
      rght_rise = en && rght_opn && !rght_prev_q;
   end

endmodule

// File: rtl/nav_speed_ctrl.sv
// nav_speed_ctrl: navigation sequencer feeding the heading PID.
//   clk, rst_n           - clock, async active-low reset
//   strt_hdng, strt_mv   - one-cycle command pulses (turn / forward move)
//   stp_lft, stp_rght    - stop the move on a new left / right opening
//   hdng_rdy             - speed-update strobe
//   at_hdng              - PID reports heading reached
//   lft_opn, rght_opn    - IR side openings
//   frwrd_opn            - IR path ahead clear (low = obstacle)
//   moving               - high whenever not idle
//   frwrd_spd            - registered unsigned forward speed
//   en_fusion            - speed above half of the ceiling
//   mv_cmplt             - registered one-cycle completion pulse
module nav_speed_ctrl
   import nav_pkg::*;
#(
   parameter logic [10:0] MAX_FRWRD  = MAX_FRWRD_DEF,
   parameter logic [10:0] MIN_FRWRD  = MIN_FRWRD_DEF,
   parameter logic [10:0] FRWRD_INC  = FRWRD_INC_DEF,
   parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        strt_hdng,
   input  logic        strt_mv,
   input  logic        stp_lft,
   input  logic        stp_rght,
   input  logic        hdng_rdy,
   input  logic        at_hdng,
   input  logic        lft_opn,
   input  logic        rght_opn,
   input  logic        frwrd_opn,
   output logic        moving,
   output logic [10:0] frwrd_spd,
   output logic        en_fusion,
   output logic        mv_cmplt
);

   localparam int unsigned CNT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
   localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE_CYC);

   nav_state_t       state_q, state_d;
   logic [10:0]      spd_q, spd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   decel_rate_t      rate_q, rate_d;
   logic             cmplt_q, cmplt_d;

   logic        lft_rise, rght_rise;
   logic        stop_req;
   logic        settled;
   logic        mv_load;
   logic [11:0] acc_sum;
   decel_rate_t dec_rate;
   logic [10:0] dec_amt;

   // A simultaneous strt_hdng wins, so a move only loads when no turn is requested.
   assign mv_load  = (state_q == IDLE) && strt_mv && !strt_hdng;
   assign stop_req = (lft_rise && stp_lft) || (rght_rise && stp_rght);
   assign settled  = (cnt_q == SETTLE_VAL);
   // Extra bit keeps the saturating add from wrapping near the top of the range.
   assign acc_sum  = {1'b0, spd_q} + {1'b0, FRWRD_INC};
   // An obstacle seen during a normal decel upgrades the rate on the same tick.
   assign dec_rate = ((rate_q == RATE_EMERG) || !frwrd_opn) ? RATE_EMERG : RATE_NORM;
   assign dec_amt  = decel_step(dec_rate, FRWRD_INC);

   opn_edge_det u_opn_edge_det (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (mv_load),
      .en        (state_q == ACCEL),
      .lft_opn   (lft_opn),
      .rght_opn  (rght_opn),
      .lft_rise  (lft_rise),
      .rght_rise (rght_rise)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (strt_hdng) begin
               state_d = TURN;
            end else if (strt_mv) begin
               state_d = ACCEL;
            end
         end
         TURN: begin
            if (settled && at_hdng) begin
               state_d = IDLE;
            end
         end
         ACCEL: begin
            if (!frwrd_opn || stop_req) begin
               state_d = DECEL;
            end
         end
         DECEL: begin
            if (hdng_rdy && (spd_q <= dec_amt)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: speed, settle counter, decel rate, completion pulse.
   always_comb begin
      spd_d   = spd_q;
      cnt_d   = cnt_q;
      rate_d  = rate_q;
      cmplt_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (strt_hdng) begin
               cnt_d = '0;
               spd_d = '0;
            end else if (strt_mv) begin
               spd_d = MIN_FRWRD;
            end
         end
         TURN: begin
            spd_d = '0;
            if (!settled) begin
               cnt_d = cnt_q + 1'b1;
            end else if (at_hdng) begin
               cmplt_d = 1'b1;
            end
         end
         ACCEL: begin
            // Leaving for DECEL takes priority over a coincident speed tick.
            if (!frwrd_opn) begin
               rate_d = RATE_EMERG;
            end else if (stop_req) begin
               rate_d = RATE_NORM;
            end else if (hdng_rdy) begin
               spd_d = (acc_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : acc_sum[10:0];
            end
         end
         DECEL: begin
            rate_d = dec_rate;
            if (hdng_rdy) begin
               if (spd_q <= dec_amt) begin
                  spd_d   = '0;
                  cmplt_d = 1'b1;
               end else begin
                  spd_d = spd_q - dec_amt;
               end
            end
         end
         default: begin
            spd_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spd_q   <= '0;
         cnt_q   <= '0;
         rate_q  <= RATE_NORM;
         cmplt_q <= 1'b0;
      end else begin
         spd_q   <= spd_d;
         cnt_q   <= cnt_d;
         rate_q  <= rate_d;
         cmplt_q <= cmplt_d;
      end
   end

   // Outputs.
   always_comb begin
      moving    = (state_q != IDLE);
      en_fusion = (spd_q > (MAX_FRWRD >> 1));
      frwrd_spd = spd_q;
      mv_cmplt  = cmplt_q;
   end

endmodule

// File: tb/tb_nav_speed_ctrl.sv
// tb_nav_speed_ctrl: self-checking bench for nav_speed_ctrl.
// Table-driven turn/move vectors, hand-written ramp/decel/reset sequences, then
// randomized stimulus compared against a behavioural model.
module tb_nav_speed_ctrl;

   localparam int MAXS   = 'h2A0;
   localparam int MINS   = 'h0D0;
   localparam int INC    = 'h018;
   localparam int SETTLE = 2;
   localparam int FUSE   = 'h150;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        strt_hdng, strt_mv, stp_lft, stp_rght, hdng_rdy, at_hdng;
   logic        lft_opn, rght_opn, frwrd_opn;
   logic        moving, en_fusion, mv_cmplt;
   logic [10:0] frwrd_spd;

   int n_checks = 0;
   int n_pass   = 0;

   nav_speed_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .strt_hdng (strt_hdng),
      .strt_mv   (strt_mv),
      .stp_lft   (stp_lft),
      .stp_rght  (stp_rght),
      .hdng_rdy  (hdng_rdy),
      .at_hdng   (at_hdng),
      .lft_opn   (lft_opn),
      .rght_opn  (rght_opn),
      .frwrd_opn (frwrd_opn),
      .moving    (moving),
      .frwrd_spd (frwrd_spd),
      .en_fusion (en_fusion),
      .mv_cmplt  (mv_cmplt)
   );

   always #5 clk = ~clk;

   // stim bits: {strt_hdng, strt_mv, stp_lft, stp_rght, hdng_rdy, at_hdng, lft, rght, frwrd}
   typedef struct {
      logic [8:0]  stim;
      logic        exp_mov;
      logic [10:0] exp_spd;
      logic        exp_cm;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(logic [8:0] s, logic m, logic [10:0] sp, logic c);
      vec_t v;
      v.stim = s; v.exp_mov = m; v.exp_spd = sp; v.exp_cm = c;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      hdng_rdy = 1'b1;
      cyc();
      hdng_rdy = 1'b0;
   endtask

   task automatic gap();
      repeat (9) cyc();
   endtask

   task automatic clear_in();
      strt_hdng = 0; strt_mv = 0; stp_lft = 0; stp_rght = 0; hdng_rdy = 0;
      at_hdng = 0; lft_opn = 0; rght_opn = 0; frwrd_opn = 1;
   endtask

   task automatic do_reset();
      clear_in();
      rst_n = 1'b0;
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic start_move();
      strt_mv = 1'b1;
      cyc();
      strt_mv = 1'b0;
   endtask

   task automatic ramp_max(input string name);
      start_move();
      for (int i = 1; i <= 20; i++) begin
         tick();
         gap();
      end
      check({name, " ramp top"}, frwrd_spd, MAXS);
   endtask

   // n ticks of a fixed decrement from start; completion expected on the last one.
   task automatic decel_run(input string name, input int start, input int step, input int n);
      for (int i = 1; i <= n; i++) begin
         tick();
         check($sformatf("%s spd t%0d", name, i), frwrd_spd, (i == n) ? 0 : start - i * step);
         check($sformatf("%s moving t%0d", name, i), moving, (i == n) ? 0 : 1);
         check($sformatf("%s cmplt t%0d", name, i), mv_cmplt, (i == n) ? 1 : 0);
         if (i == n) begin
            cyc();
            check({name, " cmplt width"}, mv_cmplt, 0);
         end else begin
            gap();
         end
      end
   endtask

   // Behavioural model: 0 idle, 1 turn, 2 accel, 3 decel.
   int m_state, m_spd, m_cnt, m_emerg, m_pl, m_pr, m_cmplt;

   task automatic model_step();
      int st = m_state, sp = m_spd, cn = m_cnt, em = m_emerg, pl = m_pl, pr = m_pr;
      int cm = 0, d;
      case (m_state)
         0: begin
            if (strt_hdng) begin st = 1; cn = 0; sp = 0; end
            else if (strt_mv) begin st = 2; sp = MINS; pl = lft_opn; pr = rght_opn; end
         end
         1: begin
            sp = 0;
            if (m_cnt < SETTLE) cn = m_cnt + 1;
            else if (at_hdng) begin st = 0; cm = 1; end
         end
         2: begin
            if (!frwrd_opn) begin st = 3; em = 1; end
            else if ((stp_lft && lft_opn && !m_pl) || (stp_rght && rght_opn && !m_pr)) begin
               st = 3; em = 0;
            end else if (hdng_rdy) sp = (m_spd + INC > MAXS) ? MAXS : m_spd + INC;
            pl = lft_opn; pr = rght_opn;
         end
         default: begin
            if (!frwrd_opn) em = 1;
            if (hdng_rdy) begin
               d = em ? 4 * INC : 2 * INC;
               if (m_spd <= d) begin sp = 0; st = 0; cm = 1; end
               else sp = m_spd - d;
            end
         end
      endcase
      m_state = st; m_spd = sp; m_cnt = cn; m_emerg = em; m_pl = pl; m_pr = pr; m_cmplt = cm;
   endtask

   initial begin
      vecs[0]  = mk(9'b110001001, 1, 11'h000, 0); // both starts: turn only
      vecs[1]  = mk(9'b000001001, 1, 11'h000, 0); // at_hdng ignored while settling
      vecs[2]  = mk(9'b000001001, 1, 11'h000, 0);
      vecs[3]  = mk(9'b000001001, 0, 11'h000, 1); // settled: complete
      vecs[4]  = mk(9'b000000001, 0, 11'h000, 0);
      vecs[5]  = mk(9'b011000101, 1, 11'h0D0, 0); // move with left already open
      vecs[6]  = mk(9'b011000101, 1, 11'h0D0, 0); // strt_mv in ACCEL ignored
      vecs[7]  = mk(9'b001010101, 1, 11'h0E8, 0); // no edge, tick accelerates
      vecs[8]  = mk(9'b001000001, 1, 11'h0E8, 0); // left closes
      vecs[9]  = mk(9'b001000101, 1, 11'h0E8, 0); // left reopens: stop
      vecs[10] = mk(9'b000010001, 1, 11'h0B8, 0);
      vecs[11] = mk(9'b000010001, 1, 11'h088, 0);
      vecs[12] = mk(9'b000010001, 1, 11'h058, 0);
      vecs[13] = mk(9'b000010001, 1, 11'h028, 0);
      vecs[14] = mk(9'b000010001, 0, 11'h000, 1);
      vecs[15] = mk(9'b000000001, 0, 11'h000, 0);

      clear_in();
      rst_n = 1'b0;
      #12;
      check("reset spd", frwrd_spd, 0);
      check("reset moving", moving, 0);
      check("reset fusion", en_fusion, 0);
      check("reset cmplt", mv_cmplt, 0);
      rst_n = 1'b1;
      cyc();

      // Table-driven turn and stop-on-opening vectors.
      for (int i = 0; i < 16; i++) begin
         {strt_hdng, strt_mv, stp_lft, stp_rght, hdng_rdy, at_hdng,
          lft_opn, rght_opn, frwrd_opn} = vecs[i].stim;
         cyc();
         check($sformatf("vec%0d moving", i), moving, vecs[i].exp_mov);
         check($sformatf("vec%0d spd", i), frwrd_spd, vecs[i].exp_spd);
         check($sformatf("vec%0d cmplt", i), mv_cmplt, vecs[i].exp_cm);
         check($sformatf("vec%0d fusion", i), en_fusion, (vecs[i].exp_spd > FUSE) ? 1 : 0);
      end

      // Ramp to ceiling, then normal stop on a new left opening.
      do_reset();
      start_move();
      check("t1 start spd", frwrd_spd, MINS);
      check("t1 start moving", moving, 1);
      for (int i = 1; i <= 21; i++) begin
         int e;
         e = (MINS + i * INC > MAXS) ? MAXS : MINS + i * INC;
         tick();
         check($sformatf("t1 spd t%0d", i), frwrd_spd, e);
         check($sformatf("t1 fusion t%0d", i), en_fusion, (e > FUSE) ? 1 : 0);
         gap();
      end
      stp_lft = 1'b1;
      lft_opn = 1'b1;
      cyc();
      check("t2 enter decel spd", frwrd_spd, MAXS);
      decel_run("t2", MAXS, 'h30, 14);
      clear_in();
      cyc();

      // Emergency stop from ceiling.
      ramp_max("t3a");
      frwrd_opn = 1'b0;
      cyc();
      decel_run("t3a", MAXS, 'h60, 7);
      clear_in();
      cyc();

      // Normal right-opening stop upgraded mid-decel.
      ramp_max("t3b");
      stp_rght = 1'b1;
      rght_opn = 1'b1;
      cyc();
      tick();
      check("t3b spd n1", frwrd_spd, MAXS - 'h30);
      gap();
      tick();
      check("t3b spd n2", frwrd_spd, MAXS - 'h60);
      gap();
      frwrd_opn = 1'b0;
      cyc();
      check("t3b spd held", frwrd_spd, MAXS - 'h60);
      decel_run("t3b", MAXS - 'h60, 'h60, 6);
      clear_in();
      cyc();

      // Async reset mid-accel.
      start_move();
      for (int i = 1; i <= 12; i++) begin
         tick();
         gap();
      end
      check("t6 pre spd", frwrd_spd, 'h1F0);
      check("t6 pre fusion", en_fusion, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6 async spd", frwrd_spd, 0);
      check("t6 async moving", moving, 0);
      check("t6 async fusion", en_fusion, 0);
      check("t6 async cmplt", mv_cmplt, 0);
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         hdng_rdy = (i % 5 == 0);
         cyc();
         check($sformatf("t6 idle moving c%0d", i), moving, 0);
         check($sformatf("t6 idle cmplt c%0d", i), mv_cmplt, 0);
         check($sformatf("t6 idle spd c%0d", i), frwrd_spd, 0);
      end

      // Randomized stimulus against the model.
      do_reset();
      m_state = 0; m_spd = 0; m_cnt = 0; m_emerg = 0; m_pl = 0; m_pr = 0; m_cmplt = 0;
      for (int c = 0; c < 4000; c++) begin
         strt_hdng = ($urandom_range(0, 29) == 0);
         strt_mv   = ($urandom_range(0, 9) == 0);
         stp_lft   = $urandom_range(0, 1) != 0;
         stp_rght  = $urandom_range(0, 1) != 0;
         hdng_rdy  = ($urandom_range(0, 2) == 0);
         at_hdng   = $urandom_range(0, 1) != 0;
         if ($urandom_range(0, 7) == 0) lft_opn = ~lft_opn;
         if ($urandom_range(0, 7) == 0) rght_opn = ~rght_opn;
         frwrd_opn = ($urandom_range(0, 40) != 0);
         model_step();
         cyc();
         check($sformatf("rnd spd c%0d", c), frwrd_spd, m_spd);
         check($sformatf("rnd moving c%0d", c), moving, (m_state != 0) ? 1 : 0);
         check($sformatf("rnd cmplt c%0d", c), mv_cmplt, m_cmplt);
         check($sformatf("rnd fusion c%0d", c), en_fusion, (m_spd > FUSE) ? 1 : 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
